tetris_uart_reporter: RTL and testbench
=======================================

Name: tetris_uart_reporter

Overview:
- Transmit-side counterpart to the game's UART command input path.
- Watches game status (start, over, 4-digit BCD score) and formats short ASCII status lines.
- Sends those lines byte by byte through the existing uart core's transmit handshake (transmit / tx_byte / is_transmitting).
- Sits beside the control block and owns the uart tx side that is currently tied off.

Parameters:
- SCORE_DIGITS, 4, number of BCD nibbles in the score input; nibble SCORE_DIGITS-1 is the most significant and is sent first.
- BUSY_TIMEOUT, 1_000_000, clk cycles to wait for is_transmitting to rise after a transmit pulse before the byte is treated as sent.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  game-running flag from control
- over  input  1  game-over flag from control
- score  input  4*SCORE_DIGITS  BCD score, one nibble per digit
- received  input  1  uart rx strobe (used only with ECHO_EN)
- rx_byte  input  8  uart rx data (used only with ECHO_EN)
- is_transmitting  input  1  uart tx busy
- transmit  output  1  one-cycle send strobe to uart
- tx_byte  output  8  byte to send; valid in the transmit cycle, held until the next transmit
- busy  output  1  high while a message is in flight or any request is pending

Behaviour:
- Reset values: transmit=0, tx_byte=0, busy=0. All pending flags clear, FSM in IDLE, prev_start=0, prev_over=0, prev_score=0.
- Event detection (registered edges):
  - start 0->1 sets pend_start.
  - over 0->1 sets pend_over.
  - score != prev_score while start && ~over sets pend_score.
- Coalescing:
  - Re-detecting an already-pending event leaves it pending; no queueing.
  - Score is snapshotted when its message begins, so the sent value is the newest one.
- Messages, each ending in CR (8'h0D) then LF (8'h0A):
  - START: "START"
  - SCORE: "S " followed by the digits
  - OVER: "OVER " followed by the digits
  - Digit encoding: nibble + 8'h30 when the nibble is <= 9; 8'h3F ('?') otherwise.
- Arbitration in IDLE, highest priority first: pend_over, pend_start, pend_score, (echo).
  - The selected flag clears in the cycle the message is chosen.
  - The score snapshot is captured in that same cycle.
- FSM:
  - IDLE -> LOAD when any flag is pending.
  - LOAD: drive tx_byte = the current message byte, transmit=1 for exactly one cycle -> WAIT_HI.
  - WAIT_HI: stay until is_transmitting=1 or the timeout counter reaches BUSY_TIMEOUT-1; then go to WAIT_LO.
  - WAIT_LO: stay while is_transmitting=1. On 0: if this was the last byte go to IDLE, otherwise advance the byte index and go to LOAD.
- Throughput:
  - transmit is never asserted while is_transmitting=1.
  - Minimum gap between transmit pulses is 3 cycles.
- Message boundaries: a message is never interrupted. Events arriving mid-message only set flags.
- Simultaneous events: start and over rising in the same cycle -> OVER is sent first, then START.
- Reset mid-message: the FSM aborts immediately, transmit drops to 0, and all flags clear. No partial-message resumption.
- Byte index width: clog2 of the longest message, which is 5 + SCORE_DIGITS + 2 bytes.
- busy = (state != IDLE) | any pending flag.

Optional Feature:
- Macro TETRIS_UART_ECHO_EN.
- Defined:
  - received=1 latches rx_byte into a one-byte echo buffer and sets pend_echo; a newer byte overwrites an unsent one.
  - pend_echo has the lowest priority. Its message is the single buffered byte with no CR/LF.
  - Echo of 8'h0D is sent as CR then LF.
- Not defined: received and rx_byte are ignored, the echo logic is absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then start 0->1 with is_transmitting modelled as 10 cycles high after each transmit -> bytes 53 54 41 52 54 0D 0A in order, one transmit per byte; busy drops to 0 after the final byte.
- start=1, score changes 16'h0000->16'h0120 -> "S 0120\r\n" = 53 20 30 31 32 30 0D 0A.
- During an in-flight SCORE message, score changes to 16'h0150 and then 16'h0175 -> exactly one follow-up message, "S 0175\r\n".
- start and over rise in the same cycle with score=16'h0042 -> "OVER 0042\r\n" then "START\r\n"; no SCORE message while over=1.
- Score nibble 4'hA (score=16'h00A0) -> third digit sent as 8'h3F. is_transmitting held at 0 -> each byte advances after BUSY_TIMEOUT cycles with no deadlock.
- Reset asserted on the 3rd byte of "START" -> transmit=0 the next cycle, busy=0, and no bytes sent afterwards. With TETRIS_UART_ECHO_EN defined: received with rx_byte=8'h61 -> a single byte 8'h61 is transmitted.

Source files
------------

// File: rtl/tetris_uart_reporter.sv
// Formats game status (START / score / OVER lines) as ASCII and drives it out through the uart tx handshake.
// Optional rx echo path is compiled in with `define TETRIS_UART_ECHO_EN.
module tetris_uart_reporter #(
    parameter int SCORE_DIGITS = 4,
    parameter int BUSY_TIMEOUT = 1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      over,
    input  logic [4*SCORE_DIGITS-1:0] score,
    input  logic                      received,
    input  logic [7:0]                rx_byte,
    input  logic                      is_transmitting,
    output logic                      transmit,
    output logic [7:0]                tx_byte,
    output logic                      busy
);

    localparam int SW      = 4 * SCORE_DIGITS;
    localparam int MSG_MAX = 5 + SCORE_DIGITS + 2;
    localparam int IDX_W   = $clog2(MSG_MAX);
    localparam int CNT_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;
    typedef enum logic [1:0] {MSG_START, MSG_SCORE, MSG_OVER, MSG_ECHO} msg_t;

    state_t           state, state_nx;
    msg_t             msg, sel_msg;
    logic [IDX_W-1:0] idx, last_idx;
    logic [CNT_W-1:0] to_cnt;
    logic [SW-1:0]    snap, prev_score;
    logic             prev_start, prev_over;
    logic             pend_start, pend_over, pend_score, pend_echo;
    logic             set_start, set_over, set_score;
    logic             clr_start, clr_over, clr_score;
    logic             any_pend, choose, is_last, hi_done;
    logic [7:0]       echo_tx, cur_byte, tx_hold;
    logic [3:0]       dig_nib;
    int               idx_i, dig_pos;

    assign set_start = start & ~prev_start;
    assign set_over  = over & ~prev_over;
    assign set_score = (score != prev_score) & start & ~over;

    assign any_pend = pend_over | pend_start | pend_score | pend_echo;
    assign choose   = (state == IDLE) & any_pend;

    always_comb begin
        if (pend_over)       sel_msg = MSG_OVER;
        else if (pend_start) sel_msg = MSG_START;
        else if (pend_score) sel_msg = MSG_SCORE;
        else                 sel_msg = MSG_ECHO;
    end

    assign clr_over  = choose & (sel_msg == MSG_OVER);
    assign clr_start = choose & (sel_msg == MSG_START);
    assign clr_score = choose & (sel_msg == MSG_SCORE);

    // NOTE: set wins over clear so an event landing in the arbitration cycle is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_start <= 1'b0;
            prev_over  <= 1'b0;
            prev_score <= '0;
            pend_start <= 1'b0;
            pend_over  <= 1'b0;
            pend_score <= 1'b0;
        end else begin
            prev_start <= start;
            prev_over  <= over;
            prev_score <= score;
            pend_start <= (pend_start & ~clr_start) | set_start;
            pend_over  <= (pend_over & ~clr_over) | set_over;
            pend_score <= (pend_score & ~clr_score) | set_score;
        end
    end

`ifdef TETRIS_UART_ECHO_EN
    logic [7:0] echo_buf;
    logic       clr_echo;

    assign clr_echo = choose & (sel_msg == MSG_ECHO);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_echo <= 1'b0;
            echo_buf  <= 8'h00;
            echo_tx   <= 8'h00;
        end else begin
            pend_echo <= (pend_echo & ~clr_echo) | received;
            if (received) echo_buf <= rx_byte;
            if (clr_echo) echo_tx <= echo_buf;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ^{received, rx_byte};
    assign pend_echo = 1'b0;
    assign echo_tx   = 8'h00;
`endif

    always_comb begin
        unique case (msg)
            MSG_START: last_idx = IDX_W'(6);
            MSG_SCORE: last_idx = IDX_W'(SCORE_DIGITS + 3);
            MSG_OVER:  last_idx = IDX_W'(SCORE_DIGITS + 6);
            MSG_ECHO:  last_idx = (echo_tx == CR) ? IDX_W'(1) : IDX_W'(0);
        endcase
    end

    assign is_last = (idx == last_idx);
    assign hi_done = is_transmitting | (to_cnt == CNT_LAST);
    assign idx_i   = int'(idx);

    // Digit position within the score field, 0 being the most significant nibble.
    assign dig_pos = (msg == MSG_OVER) ? idx_i - 5 : idx_i - 2;

    always_comb begin
        dig_nib = 4'h0;
        for (int d = 0; d < SCORE_DIGITS; d++)
            if (dig_pos == d) dig_nib = snap[4*(SCORE_DIGITS-1-d) +: 4];
    end

    always_comb begin
        cur_byte = 8'h00;
        unique case (msg)
            MSG_START: begin
                case (idx_i)
                    0:       cur_byte = "S";
                    1:       cur_byte = "T";
                    2:       cur_byte = "A";
                    3:       cur_byte = "R";
                    4:       cur_byte = "T";
                    5:       cur_byte = CR;
                    default: cur_byte = LF;
                endcase
            end
            MSG_SCORE: begin
                if (idx_i == 0)                      cur_byte = "S";
                else if (idx_i == 1)                 cur_byte = " ";
                else if (idx_i < 2 + SCORE_DIGITS)   cur_byte = (dig_nib <= 4'd9) ? {4'h3, dig_nib} : 8'h3F;
                else if (idx_i == 2 + SCORE_DIGITS)  cur_byte = CR;
                else                                 cur_byte = LF;
            end
            MSG_OVER: begin
                if (idx_i == 0)                      cur_byte = "O";
                else if (idx_i == 1)                 cur_byte = "V";
                else if (idx_i == 2)                 cur_byte = "E";
                else if (idx_i == 3)                 cur_byte = "R";
                else if (idx_i == 4)                 cur_byte = " ";
                else if (idx_i < 5 + SCORE_DIGITS)   cur_byte = (dig_nib <= 4'd9) ? {4'h3, dig_nib} : 8'h3F;
                else if (idx_i == 5 + SCORE_DIGITS)  cur_byte = CR;
                else                                 cur_byte = LF;
            end
            MSG_ECHO: cur_byte = (idx_i == 0) ? echo_tx : LF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_pend) state_nx = LOAD;
            LOAD:    state_nx = WAIT_HI;
            WAIT_HI: if (hi_done) state_nx = WAIT_LO;
            WAIT_LO: if (!is_transmitting) state_nx = is_last ? IDLE : LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msg     <= MSG_START;
            snap    <= '0;
            idx     <= '0;
            to_cnt  <= '0;
            tx_hold <= 8'h00;
        end else begin
            if (choose) begin
                msg  <= sel_msg;
                snap <= score;
                idx  <= '0;
            end else if (state == WAIT_LO && !is_transmitting && !is_last) begin
                idx <= idx + IDX_W'(1);
            end
            if (state == LOAD) tx_hold <= cur_byte;
            if (state == WAIT_HI && !hi_done) to_cnt <= to_cnt + CNT_W'(1);
            else                              to_cnt <= '0;
        end
    end

    always_comb begin
        transmit = (state == LOAD);
        tx_byte  = (state == LOAD) ? cur_byte : tx_hold;
        busy     = (state != IDLE) | any_pend;
    end

endmodule

// File: tb/tb_tetris_uart_reporter.sv
// Directed bench for tetris_uart_reporter: a simple uart tx model captures every byte sent,
// and each step compares the captured stream with hand-written expected messages.
module tb_tetris_uart_reporter;

    localparam int DIGITS   = 4;
    localparam int TIMEOUT  = 16;
    localparam int BUSY_CYC = 10;
    localparam int BUDGET   = 3000;

    logic                clk;
    logic                reset;
    logic                start;
    logic                over;
    logic [4*DIGITS-1:0] score;
    logic                received;
    logic [7:0]          rx_byte;
    logic                is_transmitting;
    logic                transmit;
    logic [7:0]          tx_byte;
    logic                busy;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    int         tx_cnt = 0;
    int         since_last = 1000;
    int         last_gap = 0;
    int         proto_err = 0;
    bit         uart_dead = 1'b0;

    tetris_uart_reporter #(
        .SCORE_DIGITS(DIGITS),
        .BUSY_TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .over           (over),
        .score          (score),
        .received       (received),
        .rx_byte        (rx_byte),
        .is_transmitting(is_transmitting),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Uart model: busy for BUSY_CYC cycles after each transmit, or never busy when uart_dead is set.
    initial is_transmitting = 1'b0;
    always @(negedge clk) begin
        since_last++;
        if (transmit === 1'b1) begin
            cap_q.push_back(tx_byte);
            if (is_transmitting !== 1'b0) proto_err++;
            if (since_last < 3) proto_err++;
            last_gap   = since_last;
            since_last = 0;
            tx_cnt     = uart_dead ? 0 : BUSY_CYC;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        is_transmitting = (tx_cnt > 0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        over  = 1'b0;
        score = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (2) tick();
        while (busy !== 1'b0 && n < BUDGET) begin
            tick();
            n++;
        end
        check({tag, " finished within budget"}, 32'(n < BUDGET), 32'd1);
    endtask

    task automatic push_str(input string s, input bit crlf);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic expect_bytes(input string tag);
        check({tag, " byte count"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s byte %0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        int pulses;

        reset    = 1'b1;
        start    = 1'b0;
        over     = 1'b0;
        score    = '0;
        received = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset transmit", 32'(transmit), 32'd0);
        check("reset tx_byte", 32'(tx_byte), 32'h00);
        check("reset busy", 32'(busy), 32'd0);

        // START line on the rising edge of start
        start = 1'b1;
        tick();
        check("busy after start edge", 32'(busy), 32'd1);
        wait_idle("start msg");
        push_str("START", 1'b1);
        expect_bytes("start msg");

        // Score change while running
        score = 16'h0120;
        wait_idle("score 0120");
        push_str("S 0120", 1'b1);
        expect_bytes("score 0120");

        // Two changes during an in-flight score line coalesce into one follow-up with the newest value
        score = 16'h0200;
        repeat (20) tick();
        score = 16'h0150;
        repeat (20) tick();
        score = 16'h0175;
        wait_idle("score coalesce");
        push_str("S 0200", 1'b1);
        push_str("S 0175", 1'b1);
        expect_bytes("score coalesce");

        // start and over together: OVER first, then START; score changes while over=1 are ignored
        apply_reset();
        score = 16'h0042;
        repeat (2) tick();
        check("no score event while stopped", 32'(busy), 32'd0);
        start = 1'b1;
        over  = 1'b1;
        repeat (30) tick();
        score = 16'h0043;
        wait_idle("over+start");
        push_str("OVER 0042", 1'b1);
        push_str("START", 1'b1);
        expect_bytes("over+start");

        // Silent uart: every byte advances on the busy timeout; non-BCD nibble prints '?'
        apply_reset();
        uart_dead = 1'b1;
        start = 1'b1;
        wait_idle("timeout start");
        push_str("START", 1'b1);
        expect_bytes("timeout start");
        score = 16'h00A0;
        wait_idle("timeout score");
        push_str("S 00?0", 1'b1);
        expect_bytes("timeout score");
        check("timeout pulse spacing", 32'(last_gap), 32'(TIMEOUT + 2));
        uart_dead = 1'b0;

        // Reset during the third byte of START aborts the line for good
        apply_reset();
        start  = 1'b1;
        n      = 0;
        pulses = 0;
        while (pulses < 3 && n < BUDGET) begin
            tick();
            if (transmit === 1'b1) pulses++;
            n++;
        end
        check("third byte reached", 32'(pulses), 32'd3);
        reset = 1'b1;
        start = 1'b0;
        tick();
        check("transmit after mid-reset", 32'(transmit), 32'd0);
        check("busy after mid-reset", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (200) tick();
        check("busy stays low after abort", 32'(busy), 32'd0);
        push_str("STA", 1'b0);
        expect_bytes("aborted start");

`ifdef TETRIS_UART_ECHO_EN
        rx_byte  = 8'h61;
        received = 1'b1;
        tick();
        received = 1'b0;
        wait_idle("echo");
        exp_q.push_back(8'h61);
        expect_bytes("echo");
`else
        rx_byte  = 8'h61;
        received = 1'b1;
        tick();
        received = 1'b0;
        repeat (40) tick();
        check("rx ignored busy", 32'(busy), 32'd0);
        expect_bytes("rx ignored");
`endif

        check("handshake protocol violations", 32'(proto_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
